// File: rtl/cam_pkg.sv
// Shared types and defaults for the quad-camera DDR write scheduler.
package cam_pkg;
  localparam int CH_NUM        = 4;
  localparam int BURST_LEN_D   = 64;
  localparam int FRAME_WORDS_D = 518400;

  typedef enum logic [1:0] {IDLE, ARB, CMD, XFER} sched_state_t;
endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter; priority starts one past the last grant.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt,
  output logic       any
);
  logic [1:0] idx;

  always_comb begin
    gnt = last;
    idx = last;
    any = |req;
    // Walk from lowest to highest priority so the closest requester wins.
    for (int i = 3; i >= 0; i--) begin
      idx = last + 2'(i + 1);
      if (req[idx]) gnt = idx;
    end
  end
endmodule

// File: rtl/cam_wr_sched.sv
// Round-robin DDR write scheduler for four camera FIFOs with per-channel frame addressing.
module cam_wr_sched
  import cam_pkg::*;
#(
  parameter int BURST_LEN    = BURST_LEN_D,
  parameter int CNT_W        = 10,
  parameter int ADDR_W       = 28,
  parameter int FRAME_WORDS  = FRAME_WORDS_D,
  parameter int FRAME_STRIDE = 524288
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [CH_NUM-1:0]       ch_vs,
  input  logic [CH_NUM*CNT_W-1:0] ch_fifo_cnt,
  input  logic                    cmd_ready,
  input  logic                    wr_data_req,
  input  logic                    wr_done,
  output logic                    cmd_valid,
  output logic [ADDR_W-1:0]       cmd_addr,
  output logic [7:0]              cmd_len,
  output logic [1:0]              grant_ch,
  output logic [CH_NUM-1:0]       fifo_rd_en,
  output logic                    busy
);
  sched_state_t state;

  logic [CH_NUM-1:0][CNT_W-1:0]  cnt;
  logic [CH_NUM-1:0][ADDR_W-1:0] offset;
  logic [CH_NUM-1:0] vs_q, rise, fall, flush, pend, req, own, done_own;
  logic [1:0]        last_grant, arb_gnt;
  logic              arb_any;
  logic [ADDR_W-1:0] sel_cnt, room, len_w, sum_off, next_off, base;

  assign cnt  = ch_fifo_cnt;
  assign rise = ch_vs & ~vs_q;
  assign fall = ~ch_vs & vs_q;

  rr_arb4 u_arb (.req(req), .last(last_grant), .gnt(arb_gnt), .any(arb_any));

  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      req[c] = (cnt[c] >= CNT_W'(BURST_LEN)) || (flush[c] && cnt[c] != '0);
      // A channel owns the port from the ARB cycle that picks it until wr_done.
      own[c] = (((state == CMD) || (state == XFER)) && grant_ch == 2'(c)) ||
               ((state == ARB) && arb_any && arb_gnt == 2'(c));
      done_own[c] = (state == XFER) && wr_done && grant_ch == 2'(c);
    end
  end

  always_comb begin
    sel_cnt = ADDR_W'(cnt[arb_gnt]);
    room    = ADDR_W'(FRAME_WORDS) - offset[arb_gnt];
    len_w   = sel_cnt;
    if (len_w > ADDR_W'(BURST_LEN)) len_w = ADDR_W'(BURST_LEN);
    if (len_w > room)               len_w = room;
    base     = ADDR_W'(FRAME_STRIDE) * ADDR_W'(arb_gnt);
    sum_off  = offset[grant_ch] + ADDR_W'(cmd_len);
    next_off = (sum_off >= ADDR_W'(FRAME_WORDS)) ? '0 : sum_off;
  end

  always_comb begin
    fifo_rd_en = '0;
    if (state == XFER) fifo_rd_en[grant_ch] = wr_data_req;
  end

  // Per-channel edge, flush, pending-clear and offset tracking.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_q   <= '0;
      flush  <= '0;
      pend   <= '0;
      offset <= '0;
    end else begin
      vs_q <= ch_vs;
      for (int c = 0; c < CH_NUM; c++) begin
        if (fall[c])                             flush[c] <= 1'b1;
        else if (state == ARB && cnt[c] == '0)   flush[c] <= 1'b0;
        if (done_own[c]) begin
          offset[c] <= (pend[c] || rise[c]) ? '0 : next_off;
          pend[c]   <= 1'b0;
        end else if (rise[c]) begin
          if (own[c]) pend[c]   <= 1'b1;
          else        offset[c] <= '0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      cmd_valid  <= 1'b0;
      cmd_addr   <= '0;
      cmd_len    <= '0;
      grant_ch   <= '0;
      last_grant <= 2'd3;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          state <= ARB;
          busy  <= 1'b1;
        end
        ARB: if (arb_any) begin
          grant_ch  <= arb_gnt;
          cmd_addr  <= base + offset[arb_gnt];
          cmd_len   <= len_w[7:0];
          cmd_valid <= 1'b1;
          state     <= CMD;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        CMD: if (cmd_ready) begin
          cmd_valid <= 1'b0;
          state     <= XFER;
        end
        XFER: if (wr_done) begin
          last_grant <= grant_ch;
          state      <= ARB;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
